rgb_fade_sequencer: RTL

Programmable colour sequencer driving the three `ONION_PWM` duty-cycle inputs (red/green/blue) of the FPGA top level. It steps through a small register-file palette, holds each colour for a fixed time, then fades linearly to the next entry at one LSB per tick. It replaces the hard-coded state/duty decode in the top level and exposes a write port so firmware-side logic can load new colours.

---
 rtl/rgb_seq_pkg.sv | 28 ++
 rtl/rgb_seq_palette.sv | 33 +++
 rtl/rgb_fade_sequencer.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/rgb_seq_pkg.sv
// Shared FSM state type, default palette and step-width helper for the RGB fade sequencer.
package rgb_seq_pkg;

   typedef enum logic [1:0] {
      RGB_SEQ_IDLE = 2'd0,
      RGB_SEQ_HOLD = 2'd1,
      RGB_SEQ_FADE = 2'd2
   } rgb_seq_state_e;

   localparam int RGB_SEQ_DEFAULT_STEPS = 8;

   // Yellow ramp (red = green) finishing on pure red; entry 0 is the last element.
   localparam logic [RGB_SEQ_DEFAULT_STEPS-1:0][23:0] RGB_SEQ_DEFAULT_PALETTE = {
      {8'd255, 8'd0,   8'd0},
      {8'd150, 8'd150, 8'd0},
      {8'd127, 8'd127, 8'd0},
      {8'd100, 8'd100, 8'd0},
      {8'd80,  8'd80,  8'd0},
      {8'd60,  8'd60,  8'd0},
      {8'd40,  8'd40,  8'd0},
      {8'd20,  8'd20,  8'd0}
   };

   function automatic int rgb_seq_step_w(input int num_steps);
      return (num_steps > 32'sd1) ? $clog2(num_steps) : 32'sd1;
   endfunction

endpackage

// File: rtl/rgb_seq_palette.sv
// Colour palette register file: synchronous write port, asynchronous read, reset to the
// initial palette.
module rgb_seq_palette
   import rgb_seq_pkg::*;
#(
   parameter int NUM_STEPS           = 8,
   parameter int PWM_RESOLUTION_BITS = 8,
   parameter int STEP_W              = rgb_seq_step_w(NUM_STEPS),
   parameter logic [NUM_STEPS-1:0][3*PWM_RESOLUTION_BITS-1:0] INIT_PALETTE = RGB_SEQ_DEFAULT_PALETTE
)(
   input  logic                               clk,
   input  logic                               reset,
   input  logic                               wr_en,
   input  logic [STEP_W-1:0]                  wr_addr,
   input  logic [3*PWM_RESOLUTION_BITS-1:0]   wr_data,
   input  logic [STEP_W-1:0]                  rd_addr,
   output logic [3*PWM_RESOLUTION_BITS-1:0]   rd_data
);

   logic [NUM_STEPS-1:0][3*PWM_RESOLUTION_BITS-1:0] mem_r;

   // Palette storage; reset wins over a simultaneous write.
   always_ff @(posedge clk) begin
      if (reset) begin
         mem_r <= INIT_PALETTE;
      end else if (wr_en) begin
         mem_r[wr_addr] <= wr_data;
      end
   end

   assign rd_data = mem_r[rd_addr];

endmodule

// File: rtl/rgb_fade_sequencer.sv
// Palette-driven RGB duty-cycle sequencer: hold each colour, then step to the next one.
// Define RGB_SEQ_FADE_EN for a linear one-LSB-per-tick fade; otherwise colours jump.
module rgb_fade_sequencer
   import rgb_seq_pkg::*;
#(
   parameter int          PWM_RESOLUTION_BITS = 8,
   parameter int          NUM_STEPS           = 8,
   parameter logic [31:0] HOLD_CYCLES         = 32'h12C0000,
   parameter logic [31:0] TICK_CYCLES         = 32'h4000,
   parameter logic [NUM_STEPS-1:0][3*PWM_RESOLUTION_BITS-1:0] INIT_PALETTE = RGB_SEQ_DEFAULT_PALETTE,
   localparam int         STEP_W              = rgb_seq_step_w(NUM_STEPS)
)(
   input  logic                               clk,
   input  logic                               reset,
   input  logic                               run,
   input  logic [STEP_W-1:0]                  last_step,
   input  logic                               wr_en,
   input  logic [STEP_W-1:0]                  wr_addr,
   input  logic [3*PWM_RESOLUTION_BITS-1:0]   wr_data,
   output logic [PWM_RESOLUTION_BITS-1:0]     red_val,
   output logic [PWM_RESOLUTION_BITS-1:0]     green_val,
   output logic [PWM_RESOLUTION_BITS-1:0]     blue_val,
   output logic                               pwm_en,
   output logic [STEP_W-1:0]                  step_idx,
   output logic                               step_done
);

   localparam int                PW        = PWM_RESOLUTION_BITS;
   localparam logic [STEP_W-1:0] MAX_IDX   = STEP_W'(NUM_STEPS - 1);
   localparam logic [31:0]       HOLD_LAST = HOLD_CYCLES - 32'd1;
`ifdef RGB_SEQ_FADE_EN
   localparam logic [31:0]       TICK_LAST = TICK_CYCLES - 32'd1;
`endif

   rgb_seq_state_e    state_r, state_s;
   logic [31:0]       hold_cnt_r, hold_cnt_s;
   logic [PW-1:0]     red_r, red_s, green_r, green_s, blue_r, blue_s;
   logic              pwm_en_r, pwm_en_s, step_done_r, step_done_s;
   logic [STEP_W-1:0] step_idx_r, step_idx_s;
   logic [STEP_W-1:0] last_step_c_s, next_idx_s, rd_addr_s;
   logic [3*PW-1:0]   rd_data_s;
   logic [PW-1:0]     tgt_red_s, tgt_green_s, tgt_blue_s;
`ifdef RGB_SEQ_FADE_EN
   logic [31:0]       tick_cnt_r, tick_cnt_s;
   logic              at_target_s;
`endif

   function automatic logic [PW-1:0] step_toward(input logic [PW-1:0] cur, input logic [PW-1:0] tgt);
      logic [PW-1:0] res;
      if (cur < tgt) begin
         res = cur + PW'(1'b1);
      end else if (cur > tgt) begin
         res = cur - PW'(1'b1);
      end else begin
         res = cur;
      end
      return res;
   endfunction

   // '>=' rather than '==' so a last_step lowered below the current index still wraps.
   assign last_step_c_s = (last_step > MAX_IDX) ? MAX_IDX : last_step;
   assign next_idx_s    = (step_idx_r >= last_step_c_s) ? {STEP_W{1'b0}} : step_idx_r + STEP_W'(1'b1);

`ifdef RGB_SEQ_FADE_EN
   assign rd_addr_s   = step_idx_r;
`else
   assign rd_addr_s   = (state_r == RGB_SEQ_HOLD) ? next_idx_s : step_idx_r;
`endif

   rgb_seq_palette #(
      .NUM_STEPS           (NUM_STEPS),
      .PWM_RESOLUTION_BITS (PW),
      .STEP_W              (STEP_W),
      .INIT_PALETTE        (INIT_PALETTE)
   ) u_palette (
      .clk     (clk),
      .reset   (reset),
      .wr_en   (wr_en),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .rd_addr (rd_addr_s),
      .rd_data (rd_data_s)
   );

   assign tgt_red_s   = rd_data_s[3*PW-1:2*PW];
   assign tgt_green_s = rd_data_s[2*PW-1:PW];
   assign tgt_blue_s  = rd_data_s[PW-1:0];
`ifdef RGB_SEQ_FADE_EN
   assign at_target_s = (red_r == tgt_red_s) && (green_r == tgt_green_s) && (blue_r == tgt_blue_s);
`endif

   // Next-state and next-datapath decode; run=0 forces everything back to idle.
   always_comb begin
      state_s     = state_r;
      hold_cnt_s  = hold_cnt_r;
      red_s       = red_r;
      green_s     = green_r;
      blue_s      = blue_r;
      pwm_en_s    = pwm_en_r;
      step_idx_s  = step_idx_r;
      step_done_s = 1'b0;
`ifdef RGB_SEQ_FADE_EN
      tick_cnt_s  = tick_cnt_r;
`endif
      if (!run) begin
         state_s    = RGB_SEQ_IDLE;
         hold_cnt_s = 32'd0;
         red_s      = {PW{1'b0}};
         green_s    = {PW{1'b0}};
         blue_s     = {PW{1'b0}};
         pwm_en_s   = 1'b0;
         step_idx_s = {STEP_W{1'b0}};
`ifdef RGB_SEQ_FADE_EN
         tick_cnt_s = 32'd0;
`endif
      end else begin
         case (state_r)
            RGB_SEQ_IDLE: begin
               state_s    = RGB_SEQ_HOLD;
               hold_cnt_s = 32'd0;
               red_s      = tgt_red_s;
               green_s    = tgt_green_s;
               blue_s     = tgt_blue_s;
               pwm_en_s   = 1'b1;
               step_idx_s = {STEP_W{1'b0}};
            end
            RGB_SEQ_HOLD: begin
               if (hold_cnt_r == HOLD_LAST) begin
                  hold_cnt_s = 32'd0;
                  step_idx_s = next_idx_s;
`ifdef RGB_SEQ_FADE_EN
                  state_s    = RGB_SEQ_FADE;
                  tick_cnt_s = 32'd0;
`else
                  red_s       = tgt_red_s;
                  green_s     = tgt_green_s;
                  blue_s      = tgt_blue_s;
                  step_done_s = 1'b1;
`endif
               end else begin
                  hold_cnt_s = hold_cnt_r + 32'd1;
               end
            end
`ifdef RGB_SEQ_FADE_EN
            RGB_SEQ_FADE: begin
               if (at_target_s) begin
                  state_s     = RGB_SEQ_HOLD;
                  hold_cnt_s  = 32'd0;
                  tick_cnt_s  = 32'd0;
                  step_done_s = 1'b1;
               end else if (tick_cnt_r == TICK_LAST) begin
                  tick_cnt_s = 32'd0;
                  red_s      = step_toward(red_r, tgt_red_s);
                  green_s    = step_toward(green_r, tgt_green_s);
                  blue_s     = step_toward(blue_r, tgt_blue_s);
               end else begin
                  tick_cnt_s = tick_cnt_r + 32'd1;
               end
            end
`endif
            default: begin
               state_s    = RGB_SEQ_IDLE;
               hold_cnt_s = 32'd0;
               red_s      = {PW{1'b0}};
               green_s    = {PW{1'b0}};
               blue_s     = {PW{1'b0}};
               pwm_en_s   = 1'b0;
               step_idx_s = {STEP_W{1'b0}};
`ifdef RGB_SEQ_FADE_EN
               tick_cnt_s = 32'd0;
`endif
            end
         endcase
      end
   end

   // FSM state register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r <= RGB_SEQ_IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Counters and registered outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         hold_cnt_r  <= 32'd0;
         red_r       <= {PW{1'b0}};
         green_r     <= {PW{1'b0}};
         blue_r      <= {PW{1'b0}};
         pwm_en_r    <= 1'b0;
         step_idx_r  <= {STEP_W{1'b0}};
         step_done_r <= 1'b0;
`ifdef RGB_SEQ_FADE_EN
         tick_cnt_r  <= 32'd0;
`endif
      end else begin
         hold_cnt_r  <= hold_cnt_s;
         red_r       <= red_s;
         green_r     <= green_s;
         blue_r      <= blue_s;
         pwm_en_r    <= pwm_en_s;
         step_idx_r  <= step_idx_s;
         step_done_r <= step_done_s;
`ifdef RGB_SEQ_FADE_EN
         tick_cnt_r  <= tick_cnt_s;
`endif
      end
   end

   assign red_val   = red_r;
   assign green_val = green_r;
   assign blue_val  = blue_r;
   assign pwm_en    = pwm_en_r;
   assign step_idx  = step_idx_r;
   assign step_done = step_done_r;

endmodule
